alu_cin_chain_ctrl: RTL

- Carry-in controller for multi-precision ALU operations.
- Supersedes the fixed 2:1 carry-in mux.
- Sequences an operation over NWORDS slices of the ALU datapath, one slice per cycle.
- Drives each slice's carry-in: mode-selected seed for slice 0, registered COUT of the previous slice afterwards.
- Holds the architectural carry flag used by ADC/SBC.
- Sits between the ALU decode logic and the adder slice.

---
 rtl/alu_cin_chain_ctrl_if.sv | 39 +++
 rtl/alu_cin_chain_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_cin_chain_ctrl_if.sv
// Bus between ALU decode/adder slice and the carry-in chain controller.
// Macro CIN_CHAIN_ZFLAG_EN adds the ZERO_IN / Z_FLAG pair.
interface alu_cin_chain_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             START;
  logic [1:0]       MODE;
  logic             COUT;
  logic             FLAG_WE;
  logic             FLAG_D;
  logic             CIN;
  logic             SLICE_VALID;
  logic [IDX_W-1:0] SLICE_IDX;
  logic             BUSY;
  logic             DONE;
  logic             C_FLAG;
`ifdef CIN_CHAIN_ZFLAG_EN
  logic             ZERO_IN;
  logic             Z_FLAG;

  modport master (
    output START, MODE, COUT, FLAG_WE, FLAG_D, ZERO_IN,
    input  CIN, SLICE_VALID, SLICE_IDX, BUSY, DONE, C_FLAG, Z_FLAG
  );
  modport slave (
    input  START, MODE, COUT, FLAG_WE, FLAG_D, ZERO_IN,
    output CIN, SLICE_VALID, SLICE_IDX, BUSY, DONE, C_FLAG, Z_FLAG
  );
`else
  modport master (
    output START, MODE, COUT, FLAG_WE, FLAG_D,
    input  CIN, SLICE_VALID, SLICE_IDX, BUSY, DONE, C_FLAG
  );
  modport slave (
    input  START, MODE, COUT, FLAG_WE, FLAG_D,
    output CIN, SLICE_VALID, SLICE_IDX, BUSY, DONE, C_FLAG
  );
`endif
endinterface

// File: rtl/alu_cin_chain_ctrl.sv
// Carry-in chain controller: sequences NWORDS adder slices and holds C_FLAG.
// Optional zero flag enabled by macro CIN_CHAIN_ZFLAG_EN.
module alu_cin_chain_ctrl #(
  parameter int unsigned NWORDS      = 4,
  parameter int unsigned IDX_W       = 4,
  parameter logic        C_FLAG_INIT = 1'b0
) (
  input logic               CLK,
  input logic               RST,
  alu_cin_chain_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {M_ADD, M_SUB, M_ADC, M_SBC} mode_e;

  state_e           state_q, state_d;
  logic             cin_q, cin_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cflag_q, cflag_d;
  logic             last_slice;

  assign last_slice = (idx_q == IDX_W'(NWORDS - 1));

  function automatic logic seed_carry(input mode_e m, input logic cf);
    case (m)
      M_ADD:   seed_carry = 1'b0;
      M_SUB:   seed_carry = 1'b1;
      default: seed_carry = cf;
    endcase
  endfunction

`ifdef CIN_CHAIN_ZFLAG_EN
  logic zacc_q, zacc_d;
  logic zflag_q, zflag_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      cflag_q <= C_FLAG_INIT;
`ifdef CIN_CHAIN_ZFLAG_EN
      zacc_q  <= 1'b1;
      zflag_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cin_q   <= cin_d;
      idx_q   <= idx_d;
      cflag_q <= cflag_d;
`ifdef CIN_CHAIN_ZFLAG_EN
      zacc_q  <= zacc_d;
      zflag_q <= zflag_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cin_d   = cin_q;
    idx_d   = idx_q;
    cflag_d = cflag_q;
`ifdef CIN_CHAIN_ZFLAG_EN
    zacc_d  = zacc_q;
    zflag_d = zflag_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        cin_d   = 1'b0;
        idx_d   = '0;
        if (bus.FLAG_WE) cflag_d = bus.FLAG_D;
        if (bus.START) begin
          // seed is taken from the flag before any same-edge write
          state_d = S_RUN;
          cin_d   = seed_carry(mode_e'(bus.MODE), cflag_q);
`ifdef CIN_CHAIN_ZFLAG_EN
          zacc_d  = 1'b1;
`endif
        end
      end
      S_RUN: begin
        if (last_slice) begin
          state_d = S_DONE;
          cin_d   = 1'b0;
          idx_d   = '0;
          cflag_d = bus.COUT;
`ifdef CIN_CHAIN_ZFLAG_EN
          zflag_d = zacc_q & bus.ZERO_IN;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          cin_d   = bus.COUT;
`ifdef CIN_CHAIN_ZFLAG_EN
          zacc_d  = zacc_q & bus.ZERO_IN;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.CIN         = cin_q;
  assign bus.SLICE_IDX   = idx_q;
  assign bus.SLICE_VALID = (state_q == S_RUN);
  assign bus.BUSY        = (state_q == S_RUN);
  assign bus.DONE        = (state_q == S_DONE);
  assign bus.C_FLAG      = cflag_q;
`ifdef CIN_CHAIN_ZFLAG_EN
  assign bus.Z_FLAG      = zflag_q;
`endif

endmodule
